// File: rtl/ntt_addr_sched_if.sv
// ntt_addr_sched_if: handshake and address bus of the NTT address scheduler.
//   start/mode/en    : request side (driven by the controller)
//   busy/done        : operation status
//   rd_* / tw_*      : coefficient RAM read addresses and twiddle ROM index
//   stage            : current read stage
//   wr_*             : write-back addresses, rd_* delayed by the datapath latency
interface ntt_addr_sched_if #(
    parameter int LOG_N = 8
);
    logic             start;
    logic [1:0]       mode;
    logic             en;
    logic             busy;
    logic             rd_valid;
    logic [LOG_N-1:0] rd_addr_a;
    logic [LOG_N-1:0] rd_addr_b;
    logic [LOG_N-2:0] tw_addr;
    logic             tw_neg;
    logic [2:0]       stage;
    logic             wr_valid;
    logic [LOG_N-1:0] wr_addr_a;
    logic [LOG_N-1:0] wr_addr_b;
    logic             done;

    modport master (
        output start, mode, en,
        input  busy, rd_valid, rd_addr_a, rd_addr_b, tw_addr, tw_neg, stage,
               wr_valid, wr_addr_a, wr_addr_b, done
    );

    modport slave (
        input  start, mode, en,
        output busy, rd_valid, rd_addr_a, rd_addr_b, tw_addr, tw_neg, stage,
               wr_valid, wr_addr_a, wr_addr_b, done
    );
endinterface

// File: rtl/ntt_addr_sched.sv
// ntt_addr_sched: self-sequencing address scheduler for the Kyber polynomial
// unit. Walks stage/butterfly counters for forward NTT (Cooley-Tukey), inverse
// NTT (Gentleman-Sande) and basecase multiply, and delays each read pair
// PIPE_DEPTH enabled cycles to produce the matching write-back pair.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : ntt_addr_sched_if.slave (start/mode/en in; busy, rd_*, tw_*,
//          stage, wr_*, done out)
module ntt_addr_sched #(
    parameter int LOG_N      = 8,
    parameter int NUM_STAGES = LOG_N - 1,
    parameter int PIPE_DEPTH = 6,
    parameter int STAGE_GAP  = 0
) (
    input logic clk,
    input logic rst,
    ntt_addr_sched_if.slave bus
);
    localparam int N   = 1 << LOG_N;
    localparam int TWW = LOG_N - 1;
    localparam int GW  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    localparam logic [1:0] MODE_NTT  = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_MULT = 2'd2;
    localparam logic [1:0] MODE_RSV  = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, DRAIN} state_t;

    state_t           state, state_nx;
    logic [1:0]       mode_q, mode_nx;
    logic [2:0]       s_q, s_nx;
    logic [TWW-1:0]   j_q, j_nx;
    logic [GW-1:0]    gap_q, gap_nx;
    logic             rd_valid, pipe_empty, last_stage;

    // Delay line: index 1 is the newest entry, PIPE_DEPTH drives the wr_* port.
    logic [PIPE_DEPTH:1]            vld_pipe;
    logic [PIPE_DEPTH:1][LOG_N-1:0] a_pipe, b_pipe;

    logic [LOG_N-1:0] jx, len, g, o, a, b;
    logic [3:0]       sh;
    logic [TWW-1:0]   tw, tw_mask;
    logic             neg;

    assign rd_valid   = (state == ISSUE);
    assign pipe_empty = ~|vld_pipe;
    assign last_stage = (mode_q == MODE_MULT) || (s_q == 3'(NUM_STAGES - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            mode_q <= MODE_NTT;
            s_q    <= '0;
            j_q    <= '0;
            gap_q  <= '0;
        end else begin
            state  <= state_nx;
            mode_q <= mode_nx;
            s_q    <= s_nx;
            j_q    <= j_nx;
            gap_q  <= gap_nx;
        end
    end

    always_comb begin
        state_nx = state;
        mode_nx  = mode_q;
        s_nx     = s_q;
        j_nx     = j_q;
        gap_nx   = gap_q;
        if (bus.en) begin
            case (state)
                IDLE: begin
                    if (bus.start && bus.mode != MODE_RSV) begin
                        state_nx = ISSUE;
                        mode_nx  = bus.mode;
                        s_nx     = '0;
                        j_nx     = '0;
                    end
                end
                ISSUE: begin
                    // j wraps to 0 naturally after N/2-1
                    j_nx = j_q + 1'b1;
                    if (&j_q) begin
                        if (last_stage) begin
                            state_nx = DRAIN;
                        end else if (STAGE_GAP > 0) begin
                            state_nx = GAP;
                            gap_nx   = '0;
                        end else begin
                            s_nx = s_q + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == GW'(STAGE_GAP - 1)) begin
                        state_nx = ISSUE;
                        s_nx     = s_q + 1'b1;
                    end else begin
                        gap_nx = gap_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (pipe_empty) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // ---------------- address generation ----------------
    // len is always a power of two, so g*2*len is a shift and a+len an OR.
    always_comb begin
        jx      = {1'b0, j_q};
        sh      = '0;
        len     = '0;
        g       = '0;
        o       = '0;
        a       = '0;
        b       = '0;
        tw      = '0;
        tw_mask = '0;
        neg     = 1'b0;
        case (mode_q)
            MODE_NTT: begin
                sh  = 4'(LOG_N - 1) - {1'b0, s_q};
                len = LOG_N'(1) << sh;
                g   = jx >> sh;
                o   = jx & (len - LOG_N'(1));
                a   = ((g << sh) << 1) | o;
                b   = a | len;
                tw  = (TWW'(1) << s_q) + g[TWW-1:0];
            end
            MODE_INV: begin
                sh      = {1'b0, s_q} + 4'd1;
                len     = LOG_N'(1) << sh;
                g       = jx >> sh;
                o       = jx & (len - LOG_N'(1));
                a       = ((g << sh) << 1) | o;
                b       = a | len;
                // (1 << (NUM_STAGES-s)) - 1 built as a mask so it never needs
                // the extra bit that 1 << NUM_STAGES would
                tw_mask = ~({TWW{1'b1}} << (4'(NUM_STAGES) - {1'b0, s_q}));
                tw      = tw_mask - g[TWW-1:0];
            end
            MODE_MULT: begin
                a   = {j_q, 1'b0};
                b   = {j_q, 1'b1};
                tw  = TWW'(N / 4) + (j_q >> 1);
                neg = j_q[0];
            end
            default: ;
        endcase
    end

    // ---------------- write-back delay line ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            a_pipe   <= '0;
            b_pipe   <= '0;
        end else if (bus.en) begin
            vld_pipe[1] <= rd_valid;
            a_pipe[1]   <= rd_valid ? a : '0;
            b_pipe[1]   <= rd_valid ? b : '0;
            for (int i = 2; i <= PIPE_DEPTH; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                a_pipe[i]   <= a_pipe[i-1];
                b_pipe[i]   <= b_pipe[i-1];
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.busy      = (state != IDLE);
    assign bus.rd_valid  = rd_valid;
    assign bus.rd_addr_a = rd_valid ? a : '0;
    assign bus.rd_addr_b = rd_valid ? b : '0;
    assign bus.tw_addr   = rd_valid ? tw : '0;
    assign bus.tw_neg    = rd_valid & neg;
    assign bus.stage     = s_q;
    assign bus.wr_valid  = vld_pipe[PIPE_DEPTH];
    assign bus.wr_addr_a = a_pipe[PIPE_DEPTH];
    assign bus.wr_addr_b = b_pipe[PIPE_DEPTH];
    // done needs en so a stall on the final cycle cannot stretch the pulse
    assign bus.done      = (state == DRAIN) && pipe_empty && bus.en;
endmodule

// File: tb/tb_ntt_addr_sched.sv
// Scoreboard bench for ntt_addr_sched: stimulus pushes expected read pairs
// and run latencies; a negedge monitor pops and compares.
module tb_ntt_addr_sched;
    localparam int LOG_N = 8;
    localparam int N     = 256;
    localparam int HALF  = 128;
    localparam int NS    = 7;
    localparam int PD    = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ntt_addr_sched_if #(.LOG_N(LOG_N)) bif ();
    ntt_addr_sched_if #(.LOG_N(LOG_N)) gif ();

    ntt_addr_sched #(.LOG_N(LOG_N), .NUM_STAGES(NS), .PIPE_DEPTH(PD), .STAGE_GAP(0))
        u_dut (.clk(clk), .rst(rst), .bus(bif.slave));
    ntt_addr_sched #(.LOG_N(LOG_N), .NUM_STAGES(NS), .PIPE_DEPTH(PD), .STAGE_GAP(4))
        u_dut_gap (.clk(clk), .rst(rst), .bus(gif.slave));

    typedef struct {int a; int b; int tw; int neg; int s;} rd_t;
    typedef struct {int a; int b; int e;} wr_t;
    typedef struct {int lat; int nrd;} run_t;

    rd_t  rd_q[$];
    wr_t  wr_q[$];
    run_t run_q[$];

    int errors = 0;
    int checks = 0;
    int ecnt = 0, e_busy = 0, nrd_run = 0, done_cnt = 0;
    int cyc = 0, stall_at = -1;
    bit rand_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference addresses straight from the transform definitions.
    function automatic rd_t model(input int m, input int s, input int j);
        rd_t r;
        int len, g, o;
        r.s = s;
        r.neg = 0;
        if (m == 2) begin
            r.a = 2 * j; r.b = 2 * j + 1; r.tw = N / 4 + j / 2; r.neg = j % 2;
        end else if (m == 0) begin
            len = N >> (s + 1); g = j / len; o = j % len;
            r.a = g * 2 * len + o; r.b = r.a + len; r.tw = (1 << s) + g;
        end else begin
            len = 2 << s; g = j / len; o = j % len;
            r.a = g * 2 * len + o; r.b = r.a + len; r.tw = (1 << (NS - s)) - 1 - g;
        end
        return r;
    endfunction

    function automatic logic [63:0] snap_of();
        return {18'b0, bif.busy, bif.rd_valid, bif.rd_addr_a, bif.rd_addr_b, bif.tw_addr,
                bif.tw_neg, bif.stage, bif.wr_valid, bif.wr_addr_a, bif.wr_addr_b};
    endfunction

    task automatic push_run(input int m);
        int ns;
        run_t rt;
        ns = (m == 2) ? 1 : NS;
        for (int s = 0; s < ns; s++)
            for (int j = 0; j < HALF; j++)
                rd_q.push_back(model(m, s, j));
        rt.lat = ns * HALF + PD + 1;
        rt.nrd = ns * HALF;
        run_q.push_back(rt);
    endtask

    // ---------------- en driver ----------------
    initial begin
        int stall_left;
        stall_left = 0;
        bif.en = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (stall_left > 0) begin
                bif.en = 1'b0; stall_left--;
            end else if (cyc == stall_at) begin
                bif.en = 1'b0; stall_left = 2;
            end else begin
                bif.en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic busy_prev, have_prev, en_prev;
        logic [63:0] snap;
        rd_t r;
        wr_t w;
        run_t rt;
        busy_prev = 1'b0; have_prev = 1'b0; en_prev = 1'b1; snap = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                busy_prev = 1'b0;
                have_prev = 1'b0;
            end else begin
                if (have_prev && !en_prev) chk("hold", snap_of(), snap);
                if (bif.busy && !busy_prev) begin
                    e_busy = ecnt;
                    nrd_run = 0;
                end
                if (bif.en) begin
                    if (bif.rd_valid) begin
                        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                        else begin
                            r = rd_q.pop_front();
                            chk("rd_addr_a", bif.rd_addr_a, r.a);
                            chk("rd_addr_b", bif.rd_addr_b, r.b);
                            chk("tw_addr", bif.tw_addr, r.tw);
                            chk("tw_neg", bif.tw_neg, r.neg);
                            chk("stage", bif.stage, r.s);
                            w.a = r.a; w.b = r.b; w.e = ecnt;
                            wr_q.push_back(w);
                            nrd_run++;
                        end
                    end
                    if (bif.wr_valid) begin
                        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                        else begin
                            w = wr_q.pop_front();
                            chk("wr_addr_a", bif.wr_addr_a, w.a);
                            chk("wr_addr_b", bif.wr_addr_b, w.b);
                            chk("wr_latency", ecnt - w.e, PD);
                        end
                    end
                    if (bif.done) begin
                        if (run_q.size() == 0) chk("done_unexpected", 1, 0);
                        else begin
                            rt = run_q.pop_front();
                            chk("done_latency", ecnt - e_busy, rt.lat - 1);
                            chk("rd_count", nrd_run, rt.nrd);
                            chk("rd_left", rd_q.size(), 0);
                            chk("wr_left", wr_q.size(), 0);
                        end
                        done_cnt++;
                    end
                end else if (bif.done) begin
                    chk("done_in_stall", 1, 0);
                end
                busy_prev = bif.busy;
                snap      = snap_of();
                en_prev   = bif.en;
                have_prev = 1'b1;
                if (bif.en) ecnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int m, input bit hold);
        int t;
        push_run(m);
        bif.mode  = 2'(m);
        bif.start = 1'b1;
        if (!hold) begin
            t = 0;
            while (bif.busy !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
            if (t >= 50) chk("start_timeout", 0, 1);
            bif.start = 1'b0;
        end
        t = 0;
        while (bif.done !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
        if (t >= 5000) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
        bif.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("idle_after_done", bif.busy, 0);
    endtask

    task automatic reset_test();
        int d0;
        rd_t r;
        rand_en = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        push_run(0);
        bif.mode = 2'd0; bif.start = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b0;
        repeat (424) @(posedge clk);
        #2;
        r = model(0, 3, 40);
        chk("pre_rst_a", bif.rd_addr_a, r.a);
        chk("pre_rst_b", bif.rd_addr_b, r.b);
        #1 rst = 1'b0;
        #1;
        chk("rst_outputs", snap_of(), 0);
        chk("rst_done", bif.done, 0);
        rd_q.delete(); wr_q.delete(); run_q.delete();
        d0 = done_cnt;
        repeat (5) begin @(posedge clk); #1; end
        chk("no_done_on_abort", done_cnt, d0);
        rst = 1'b1;
        @(posedge clk); #1;
        run(0, 1'b0);
    endtask

    task automatic gap_test();
        int k, r, first, last, zrun, nruns, badruns, done_k;
        rd_t m;
        gif.mode = 2'd0; gif.start = 1'b1;
        @(posedge clk); #1;
        gif.start = 1'b0;
        k = 0; r = 0; first = -1; last = -1; zrun = 0; nruns = 0; badruns = 0; done_k = -1;
        while (k < 2000 && done_k < 0) begin
            @(negedge clk);
            k++;
            if (gif.rd_valid) begin
                if (first < 0) first = k;
                last = k;
                if (zrun > 0) begin
                    nruns++;
                    if (zrun != 4) badruns++;
                    zrun = 0;
                end
                m = model(0, r / HALF, r % HALF);
                chk("gap_rd", {gif.stage, gif.rd_addr_a, gif.rd_addr_b, gif.tw_addr},
                    m.s * (1 << 23) + m.a * (1 << 15) + m.b * (1 << 7) + m.tw);
                r++;
            end else if (first >= 0 && r < NS * HALF) begin
                zrun++;
            end
            if (gif.done) done_k = k;
        end
        chk("gap_rd_count", r, NS * HALF);
        chk("gap_rd_span", last - first + 1, NS * HALF + (NS - 1) * 4);
        chk("gap_runs", nruns, NS - 1);
        chk("gap_bad_runs", badruns, 0);
        chk("gap_done_latency", done_k, NS * HALF + (NS - 1) * 4 + PD + 1);
    endtask

    initial begin
        rst = 1'b1;
        bif.start = 1'b0; bif.mode = 2'd0;
        gif.start = 1'b0; gif.mode = 2'd0; gif.en = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("reset_outputs", snap_of(), 0);
        chk("reset_done", bif.done, 0);
        chk("reset_gap_busy", {gif.busy, gif.rd_valid, gif.wr_valid, gif.done}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // NTT with start held through busy and a 3-cycle stall mid-stage
        stall_at = cyc + 300;
        run(0, 1'b1);
        stall_at = -1;

        // INVNTT with random stalls, start held into the done cycle
        rand_en = 1'b1;
        run(1, 1'b1);

        // reserved mode is ignored
        bif.mode = 2'd3; bif.start = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        chk("rsv_busy", bif.busy, 0);
        chk("rsv_rd_valid", bif.rd_valid, 0);
        bif.start = 1'b0;

        run(2, 1'b0);
        repeat (3) run(int'($urandom_range(0, 2)), 1'b0);

        reset_test();
        gap_test();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ntt_addr_sched.md
Name: ntt_addr_sched

Overview:
- Self-sequencing address scheduler for the Kyber polynomial arithmetic unit. It is a parametrised successor to the externally-counted NTT address generator.
- Contains its own stage/butterfly counters and a start/busy/done handshake, plus a stall input and a configurable write-back delay line.
- Supports an optional inter-stage bubble insertion for RAW-hazard avoidance.
- Drives coefficient RAM read/write ports and the twiddle ROM for forward NTT (Cooley-Tukey), inverse NTT (Gentleman-Sande) and basecase multiply.

Parameters:
LOG_N, 8, log2 of polynomial length N (N=256 coefficients, one per RAM address)
NUM_STAGES, LOG_N-1, butterfly stages per transform (7 for Kyber)
PIPE_DEPTH, 6, butterfly datapath latency in enabled cycles (read issue to write-back)
STAGE_GAP, 0, idle read cycles inserted between consecutive NTT/INVNTT stages

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  start request, sampled when busy=0
mode  input  2  0=NTT, 1=INVNTT, 2=MULT, 3=reserved; latched on accepted start
en  input  1  global advance enable; 0 freezes all state
busy  output  1  operation in progress
rd_valid  output  1  read addresses valid this cycle
rd_addr_a  output  LOG_N  first butterfly operand address
rd_addr_b  output  LOG_N  second butterfly operand address
tw_addr  output  LOG_N-1  twiddle ROM index
tw_neg  output  1  MULT only: negate twiddle (odd pair)
stage  output  3  current read stage index
wr_valid  output  1  write-back addresses valid
wr_addr_a  output  LOG_N  rd_addr_a delayed PIPE_DEPTH enabled cycles
wr_addr_b  output  LOG_N  rd_addr_b delayed PIPE_DEPTH enabled cycles
done  output  1  single-cycle completion pulse

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=IDLE, counters and delay line cleared. Reset mid-operation aborts with no done pulse.
- FSM states: IDLE, ISSUE, GAP, DRAIN.
  - IDLE: start=1 and en=1 and mode!=3 -> latch mode, clear s and j, go to ISSUE, set busy=1 next cycle. Reserved mode is ignored and the FSM stays in IDLE.
  - ISSUE: rd_valid=1, one butterfly per enabled cycle. j counts 0..N/2-1. At j=N/2-1:
    - last stage (or MULT) -> DRAIN.
    - otherwise, STAGE_GAP>0 -> GAP.
    - otherwise -> ISSUE with s+1, j=0, no bubble.
  - GAP: rd_valid=0 for STAGE_GAP enabled cycles, then ISSUE with s+1.
  - DRAIN: rd_valid=0 until the delay line is empty, then pulse done for 1 cycle and return to IDLE. busy=0 from the cycle after done.
- start is ignored while busy=1, including the done cycle.
- Address rules, with s = stage and j = butterfly index:
  - NTT: len=N>>(s+1), g=j>>(LOG_N-1-s), o=j&(len-1).
    - a=g*2*len+o, b=a+len, tw=(1<<s)+g.
  - INVNTT: len=1<<(s+1), g=j>>(s+1), o=j&(len-1).
    - a=g*2*len+o, b=a+len, tw=(1<<(NUM_STAGES-s))-1-g.
  - MULT: single pass, s=0, p=j.
    - a=2p, b=2p+1, tw=N/4+(p>>1), tw_neg=p[0].
  - tw_neg=0 outside MULT.
- Width rule: all arithmetic is exact within LOG_N bits; no wrap is permitted for legal indices.
- Stall (en=0): counters, FSM, GAP count and delay line all hold. rd_valid and wr_valid hold their values, and the datapath must also stall.
- Delay line: PIPE_DEPTH-entry shift register carrying {valid,a,b}, advancing only when en=1. wr_* outputs equal the last entry. wr_valid=1 exactly PIPE_DEPTH enabled cycles after each rd_valid=1.
- Cycle count with en held high, from start acceptance to done:
  - NTT/INVNTT: NUM_STAGES*N/2 + (NUM_STAGES-1)*STAGE_GAP + PIPE_DEPTH + 1.
  - MULT: N/2 + PIPE_DEPTH + 1.

Test Plan:
- NTT, defaults, start with mode=0 -> first rd: a=0,b=128,tw=1; s0 j=127: a=127,b=255,tw=1; s6 j=0: a=0,b=2,tw=64; s6 j=127: a=253,b=255,tw=127; 896 rd_valid cycles; done 903 cycles after start.
- INVNTT, mode=1 -> s0 j=0: a=0,b=2,tw=127; s0 j=127: a=253,b=255,tw=64; s6 j=5: a=5,b=133,tw=1.
- MULT, mode=2 -> p=3: a=6,b=7,tw=65,tw_neg=1; p=127: a=254,b=255,tw=127,tw_neg=1; exactly 128 issues; done pulse once.
- Stall/latency: en=0 for 3 cycles mid-stage -> all outputs frozen. Every wr_addr pair equals the rd pair issued 6 enabled cycles earlier; no lost or duplicate writes (896 wr_valid total).
- STAGE_GAP=4 -> 4 rd_valid=0 cycles between each of the 6 stage boundaries; total 920 rd-phase cycles. A start asserted during busy, or with mode=3 while idle, is ignored.
- Reset: rst=0 at s3 j=40 -> all outputs 0 immediately, no done pulse. A new start after release runs a full NTT correctly from a=0,b=128.
